// File: rtl/hex_display_counter.sv
// hex_display_counter: rate-divided 16-bit up/down counter with start/stop/load control feeding four hex decoders.
module hex_display_counter #(
  parameter int DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        up,
  input  logic [1:0]  speed,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic        running,
  output logic        paused,
  output logic        wrap
);
  localparam int DW = $clog2(4 * DIV);
  localparam logic [DW-1:0] P1 = DW'(DIV - 1);
  localparam logic [DW-1:0] P2 = DW'(2 * DIV - 1);
  localparam logic [DW-1:0] P4 = DW'(4 * DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d, pm1;
  logic wrap_q, wrap_d, start_q, stop_q, start_e, stop_e;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      wrap_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      wrap_q  <= wrap_d;
      start_q <= start;
      stop_q  <= stop;
    end
  // Reload value tracks speed live, so a speed change lands at the next reload.
  always_comb begin
    start_e = start & ~start_q;
    stop_e  = stop & ~stop_q;
    pm1     = speed == 2'd0 ? '0 : speed == 2'd1 ? P1 : speed == 2'd2 ? P2 : P4;
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    wrap_d  = 1'b0;
    if (load) begin
      cnt_d = load_value;
      div_d = pm1;
    end else begin
      case (state_q)
        IDLE: if (start_e && !stop_e) begin
          state_d = RUN;
          div_d   = pm1;
        end
        RUN: if (stop_e) state_d = PAUSED;
        else if (div_q == '0) begin
          cnt_d  = up ? cnt_q + 16'd1 : cnt_q - 16'd1;
          wrap_d = up ? &cnt_q : ~|cnt_q;
          div_d  = pm1;
        end else div_d = div_q - 1'b1;
        PAUSED: if (stop_e) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start_e) begin
          state_d = RUN;
          div_d   = pm1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign {hex3, hex2, hex1, hex0} = cnt_q;
  assign running = state_q == RUN;
  assign paused  = state_q == PAUSED;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_hex_display_counter.sv
// tb_hex_display_counter: randomized and directed checks against a time-based behavioural model.
module tb_hex_display_counter;
  localparam int DIV = 4;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, load = 1'b0, up = 1'b1;
  logic [15:0] load_value = '0;
  logic [1:0] speed = '0;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic running, paused, wrap;
  int total = 0, bad = 0;
  int m_mode, m_cnt, n, next_at;
  bit m_wrap, ps, pst;
  always #5 clock = ~clock;
  hex_display_counter #(.DIV(DIV)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_value(load_value), .up(up), .speed(speed),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .running(running), .paused(paused), .wrap(wrap)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask
  function automatic int per(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? DIV : s == 2'd2 ? 2 * DIV : 4 * DIV;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_wrap = 0; ps = 0; pst = 0;
  endtask
  // mode 0 idle, 1 run, 2 paused; next_at is the absolute edge index of the next step
  task automatic model_edge();
    bit se, te;
    int t;
    n++;
    if (reset) begin
      model_reset();
      return;
    end
    se = start && !ps;
    te = stop && !pst;
    ps = start;
    pst = stop;
    m_wrap = 0;
    if (load) begin
      m_cnt = load_value;
      next_at = n + per(speed);
    end else if (m_mode == 1) begin
      if (te) m_mode = 2;
      else if (n == next_at) begin
        t = m_cnt + (up ? 1 : -1);
        m_wrap = t < 0 || t > 65535;
        m_cnt = (t + 65536) % 65536;
        next_at = n + per(speed);
      end
    end else if (te) begin
      if (m_mode == 2) m_cnt = 0;
      m_mode = 0;
    end else if (se) begin
      m_mode = 1;
      next_at = n + per(speed);
    end
  endtask
  function automatic logic [15:0] cnt_o();
    return {hex3, hex2, hex1, hex0};
  endfunction
  task automatic check_all();
    chk("count", cnt_o(), m_cnt);
    chk("running", running, m_mode == 1);
    chk("paused", paused, m_mode == 2);
    chk("wrap", wrap, m_wrap);
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clock);
      model_edge();
      #1 check_all();
    end
  endtask
  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask
  task automatic pulse_stop();
    stop = 1; tick(); stop = 0; tick();
  endtask
  initial begin
    n = 0; next_at = 0;
    model_reset();
    tick(2);
    reset = 0;
    tick();
    chk("reset_count", cnt_o(), 0);
    speed = 2'd1; up = 1;
    pulse_start();
    chk("run_after_start", running, 1);
    tick(4);
    chk("first_step", cnt_o(), 1);
    tick(4);
    chk("second_step", cnt_o(), 2);
    tick(4);
    chk("third_step", cnt_o(), 3);
    pulse_stop();
    tick(19);
    chk("paused_hold", cnt_o(), 3);
    pulse_start();
    tick(3);
    chk("resume_wait", cnt_o(), 3);
    tick();
    chk("resume_step", cnt_o(), 4);
    pulse_stop();
    pulse_stop();
    chk("stop_stop_clear", cnt_o(), 0);
    chk("stop_stop_idle", running | paused, 0);
    load = 1; load_value = 16'hFFFE; speed = 2'd0;
    tick();
    load = 0;
    pulse_start();
    tick();
    chk("pre_wrap", cnt_o(), 16'hFFFF);
    tick();
    chk("up_wrap_cnt", cnt_o(), 0);
    chk("up_wrap_pulse", wrap, 1);
    tick();
    chk("post_wrap", {cnt_o(), 15'd0, wrap}, {16'd1, 16'd0});
    pulse_stop();
    pulse_stop();
    load = 1; load_value = 16'h0000; up = 0;
    tick();
    load = 0;
    pulse_start();
    tick();
    chk("down_wrap", {cnt_o(), 15'd0, wrap}, {16'hFFFF, 16'd1});
    tick();
    chk("down_after", cnt_o(), 16'hFFFE);
    pulse_stop();
    pulse_stop();
    start = 1; stop = 1;
    tick();
    chk("same_edge_idle", running, 0);
    stop = 0;
    tick(3);
    start = 0;
    tick();
    start = 1;
    tick(50);
    chk("held_start", running, 1);
    start = 0; speed = 2'd0; up = 1;
    tick(5);
    @(posedge clock);
    model_edge();
    #3 reset = 1;
    #1 model_reset();
    check_all();
    chk("async_reset", {cnt_o(), 13'd0, running, paused, wrap}, 0);
    tick();
    reset = 0;
    tick(10);
    chk("no_count_after_reset", cnt_o(), 0);
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 6) == 0;
      stop = ($urandom % 25) == 0;
      load = ($urandom % 30) == 0;
      case ($urandom % 3)
        0: load_value = 16'hFFFE;
        1: load_value = 16'h0001;
        default: load_value = 16'($urandom);
      endcase
      if ($urandom % 10 == 0) up = ~up;
      if ($urandom % 12 == 0) speed = 2'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hex_display_counter.md
# hex_display_counter

Rate-divided 16-bit up/down counter with start/stop/load control whose four nibbles drive four downstream `hex_decoder` instances (HEX3..HEX0). It turns board-level buttons and switches into a steadily changing hex value at a selectable rate. It is the stage directly upstream of the 7-segment decoders and owns all timing; the decoders stay purely combinational.

## Interface
- `DIV`, default 50_000_000: base tick period in clock cycles (1 Hz at 50 MHz); must be ≥ 1.
- `clock`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  run request, level input, acted on at rising edge only.
- `stop`  in  1  pause/clear request, level input, acted on at rising edge only.
- `load`  in  1  synchronous load strobe, level-sensitive.
- `load_value`  in  16  value loaded when `load`=1.
- `up`  in  1  1 = count up, 0 = count down; sampled at each count step.
- `speed`  in  2  period P: 00 → 1, 01 → DIV, 10 → 2·DIV, 11 → 4·DIV cycles.
- `hex3`..`hex0`  out  4 each  count[15:12] .. count[3:0], to `hex_decoder.c`.
- `running`  out  1  state == RUN.
- `paused`  out  1  state == PAUSED.
- `wrap`  out  1  one-cycle pulse coincident with a wrap-around step.

## Operation
- `start` and `stop` are synchronous to `clock`. Edges are detected against a 1-cycle registered copy: `start_e = start & ~start_q`, and likewise `stop_e`.
- States: IDLE, RUN, PAUSED.
  - IDLE: `start_e` → RUN.
  - RUN: `stop_e` → PAUSED.
  - PAUSED: `start_e` → RUN; `stop_e` → IDLE and count ← 0.
- `start_e` and `stop_e` in the same cycle: stop wins (IDLE stays IDLE; RUN → PAUSED; PAUSED → IDLE).
- Priority per edge: `reset` > `load` > edge events > count step.
- `load`=1: count ← `load_value`, divider ← P−1, `wrap` ← 0. State is unchanged, and edge events in that cycle are ignored. The edge registers still update.
- Divider: down-counter sized for 4·DIV−1.
  - On entry to RUN it is set to P−1.
  - In RUN: if divider == 0, take a count step and reload P−1; otherwise decrement.
  - Divider frozen in IDLE/PAUSED.
  - P is recomputed from `speed` only at reload, so a speed change mid-period takes effect at the next step.
- Count step, 16-bit modular:
  - Up: FFFF → 0000 wraps.
  - Down: 0000 → FFFF wraps.
  - `wrap` is registered high for exactly the cycle following a wrapping step and 0 otherwise.
- Count holds in IDLE and PAUSED.

## Timing
- Reset values: count 0000 (all `hex*` = 0), state IDLE, `running` 0, `paused` 0, `wrap` 0, divider 0, `start_q` and `stop_q` 0.
  - Outputs change asynchronously on `reset` assertion, without waiting for a clock edge.
- `start_e` sampled at edge E:
  - `running` is 1 after E.
  - First count step at edge E+P; subsequent steps every P edges.
  - With speed 00, count changes on every edge after E.
- `stop_e` at edge E: `paused` after E; no count step at E even if the divider hit 0 there.
- Resume from PAUSED: a full period P elapses before the next step; the old divider residue is discarded.
- `load` at edge E: new count is visible after E; next step (if RUN) at E+P.
- `hex*`, `running`, `paused` and `wrap` are registered outputs with no combinational input-to-output path.
- A held `start` or `stop` level produces exactly one event.

## Test plan
- DIV=4, reset, speed 01, up=1, `start` high 1 cycle → `running`=1; count 0001 four edges after the start edge, 0002 after eight, `wrap` stays 0.
- `load` FFFE, speed 00, up=1, start → FFFF, then 0000 with `wrap`=1 for exactly that cycle, then 0001 with `wrap`=0; `hex3..hex0` = F,F,F,F then 0,0,0,0.
- Load 0000, up=0, speed 00, run → FFFF with `wrap` pulse; then FFFE.
- DIV=4, speed 01, run to 0003, `stop` edge → `paused`=1 and count holds for 20 cycles; `start` edge → 0004 exactly four edges later; stop, stop → IDLE and count 0000.
- `start` and `stop` rising on the same edge in IDLE → remains IDLE; `start` held high 50 cycles after a single edge → exactly one transition.
- Reset asserted mid-run between clock edges → all outputs 0 and IDLE before the next edge; after release, no counting until a new `start` edge.
